// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: a main (head) entry plus one skid entry, with flush and bubble insertion.
// Optional statistics counters are enabled by defining PIPEREG_STATS_EN.
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 128,
  parameter int CTRL_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
`ifdef PIPEREG_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;

  // Flush clears only control bits so a squashed entry becomes a bubble; payload is kept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_valid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            state     <= TWO;
          end else if (out_ready) begin
            main_ctrl <= '0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (out_ready) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            state     <= ONE;
          end
        end
        default: begin
          main_ctrl <= '0;
          state     <= EMPTY;
        end
      endcase
    end
  end

  // Outputs depend only on registered state and RST, never on out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    occupancy = 2'd0;
    if (!RST) begin
      in_ready  = (state != TWO);
      out_valid = (state != EMPTY);
      case (state)
        ONE:     occupancy = 2'd1;
        TWO:     occupancy = 2'd2;
        default: occupancy = 2'd0;
      endcase
    end
  end

  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = RST ? '0 : main_data;

`ifdef PIPEREG_STATS_EN
  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != EMPTY) && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && (state != EMPTY) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: payload bits kept on flush (operands, immediates, register indices).
REQ-002 SHALL have parameter CTRL_WIDTH, default 16: control bits zeroed on flush and on drain (RegWrite, MemRead, MemWrite, Branch, Jump, halt).
REQ-003 SHALL have parameter CNT_WIDTH, default 16: statistics counter width, used only under PIPEREG_STATS_EN.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 RST  input  1  synchronous reset, active-high.
REQ-006 in_valid  input  1  upstream stage presents an instruction.
REQ-007 in_ready  output  1  stage can accept; handshake fires when in_valid and in_ready are both high.
REQ-008 in_ctrl  input  CTRL_WIDTH  incoming control field.
REQ-009 in_data  input  DATA_WIDTH  incoming payload field.
REQ-010 flush  input  1  squash all held instructions (branch/jump redirect).
REQ-011 out_valid  output  1  stage holds an instruction for downstream.
REQ-012 out_ready  input  1  downstream accepts; handshake fires when out_valid and out_ready are both high.
REQ-013 out_ctrl  output  CTRL_WIDTH  head control field; all-zero (bubble) whenever out_valid=0.
REQ-014 out_data  output  DATA_WIDTH  head payload field.
REQ-015 occupancy  output  2  number of held entries: 0, 1 or 2.
REQ-016 stall_cnt, flush_cnt  output  CNT_WIDTH each  statistics counters, present only under PIPEREG_STATS_EN.

Function
REQ-017 SHALL hold a main register (head) and one skid register, managed by state machine EMPTY/ONE/TWO; occupancy SHALL equal 0/1/2 respectively.
REQ-018 EMPTY: in_valid -> load main, go to ONE.
REQ-019 ONE: in_valid & out_ready -> main replaced by input, stay ONE; in_valid & !out_ready -> load skid, go to TWO; !in_valid & out_ready -> EMPTY; neither -> hold.
REQ-020 TWO: out_ready -> skid moves to main, go to ONE; otherwise hold both entries.
REQ-021 in_ready SHALL equal (state != TWO) and be driven from registered state only; there SHALL be no combinational path from out_ready to in_ready.
REQ-022 out_valid SHALL equal (state != EMPTY); out_data and out_ctrl SHALL come from main.
REQ-023 Latency: an input accepted in cycle N SHALL appear on out_* in cycle N+1 when the stage was EMPTY, or when it was ONE and out_ready=1.
REQ-024 Ordering SHALL be strict FIFO; no entry SHALL be dropped or duplicated except by flush.
REQ-025 flush SHALL take priority over all handshakes: next state EMPTY, main and skid ctrl cleared to 0, data fields retained, and any input offered in the same cycle discarded.
REQ-026 A downstream handshake in the flush cycle SHALL still count as consumed downstream; the flush SHALL nonetheless empty the stage.
REQ-027 When the stage drains to EMPTY, main ctrl SHALL be cleared so that out_ctrl is 0.

Reset
REQ-028 RST high at a rising CLK edge SHALL force state EMPTY and clear main, skid and statistics counters to 0, overriding flush and any handshake.
REQ-029 While RST is high: in_ready=0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0; in the first cycle after RST deasserts, in_ready=1.

Configuration
REQ-030 Macro PIPEREG_STATS_EN defined: stall_cnt SHALL increment in each cycle with out_valid & !out_ready; flush_cnt SHALL increment in each flush cycle with state != EMPTY; both SHALL saturate at all-ones and clear on RST.
REQ-031 Macro PIPEREG_STATS_EN undefined: stall_cnt and flush_cnt ports and their logic SHALL be absent, with no other behavioural change.

Verification
REQ-032 Pass-through: out_ready=1; send 0xA1, 0xA2, 0xA3 on consecutive cycles -> each appears one cycle later; occupancy stays 1; in_ready stays 1.
REQ-033 Backpressure: out_ready=0; send 0xB1, 0xB2 -> occupancy 2, in_ready=0, out_data=0xB1; raise out_ready -> 0xB1 then 0xB2 in order, with no loss.
REQ-034 Flush in TWO: entries ctrl=0x00FF held; assert flush with in_valid=1 carrying 0xC3 -> next cycle occupancy 0, out_ctrl=0, 0xC3 never appears on out_*.
REQ-035 Reset mid-operation: occupancy 2, assert RST for 1 cycle -> all outputs 0 while RST is high; after release in_ready=1 and occupancy=0.
REQ-036 Stats (PIPEREG_STATS_EN, CNT_WIDTH=4): hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15 (saturated); one flush while non-empty -> flush_cnt=1.
